// File: rtl/pmp_scan_checker.sv
// Multi-entry PMP checker: scans NUM_ENTRIES entries LANES at a time and checks
// both the first and the last byte of each access against the lowest matching entry.
module pmp_scan_checker #(
    parameter int unsigned PA_BITS     = 56,
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned LANES       = 4,
    parameter int unsigned G           = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                ReqValid,
    output logic                                ReqReady,
    input  logic [PA_BITS-1:0]                  ReqAdr,
    input  logic [1:0]                          ReqSize,
    input  logic [2:0]                          ReqType,
    input  logic                                ReqMMode,
    input  logic [8*NUM_ENTRIES-1:0]            PMPCfg,
    input  logic [(PA_BITS-2)*NUM_ENTRIES-1:0]  PMPAdr,
    input  logic                                CfgUpdate,
    output logic                                RespValid,
    input  logic                                RespReady,
    output logic                                RespFault,
    output logic                                RespMatched,
    output logic [$clog2(NUM_ENTRIES):0]        RespIdx
);

    localparam int unsigned AW         = PA_BITS - 2;
    localparam int unsigned IW         = $clog2(NUM_ENTRIES) + 1;
    localparam int unsigned NUM_GROUPS = NUM_ENTRIES / LANES;
    localparam int unsigned GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int unsigned GSH        = (G >= 2) ? (G - 1) : 0;
    // Granule bits forced to 1 for NAPOT and to 0 for TOR when G >= 2.
    localparam logic [AW-1:0] GMASK    = AW'((64'd1 << GSH) - 64'd1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      grp_q, grp_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic [AW-1:0]      end_q, end_d;
    logic [2:0]         type_q, type_d;
    logic               mmode_q, mmode_d;
    logic               fault_q, fault_d;
    logic               matched_q, matched_d;
    logic [IW-1:0]      idx_q, idx_d;

    logic [2:0]         size_m1;
    logic [PA_BITS:0]   end_full;
    logic               last_grp;
    logic               hit;
    logic               hit_fault;
    logic [IW-1:0]      hit_idx;

    function automatic logic entry_match(
        input logic [1:0]    mode,
        input logic [AW-1:0] cur,
        input logic [AW-1:0] prev,
        input logic          first,
        input logic [AW-1:0] a
    );
        logic [AW-1:0] lo;
        logic [AW-1:0] hi;
        logic [AW-1:0] v;
        logic [AW-1:0] mask;
        lo   = first ? '0 : (prev & ~GMASK);
        hi   = cur & ~GMASK;
        v    = cur | GMASK;
        mask = v ^ (v + 1'b1);
        case (mode)
            2'b01:   entry_match = (a >= lo) && (a < hi);
            2'b10:   entry_match = (G == 0) && (a == cur);
            2'b11:   entry_match = ((a ^ v) & ~mask) == '0;
            default: entry_match = 1'b0;
        endcase
    endfunction

    assign size_m1  = 3'((4'd1 << ReqSize) - 4'd1);
    assign end_full = {1'b0, ReqAdr} + {{(PA_BITS-2){1'b0}}, size_m1};
    assign last_grp = (32'(grp_q) == NUM_GROUPS - 1);

    // Lanes are visited in ascending order so the first hit is the lowest index.
    always_comb begin
        int unsigned idx;
        int unsigned pidx;
        logic        s;
        logic        e;
        logic        permit;
        idx       = 0;
        pidx      = 0;
        s         = 1'b0;
        e         = 1'b0;
        permit    = 1'b0;
        hit       = 1'b0;
        hit_fault = 1'b0;
        hit_idx   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            idx    = 32'(grp_q) * LANES + l;
            pidx   = (idx == 0) ? 0 : idx - 1;
            s      = entry_match(PMPCfg[idx*8+3 +: 2], PMPAdr[idx*AW +: AW],
                                 PMPAdr[pidx*AW +: AW], idx == 0, adr_q);
            e      = entry_match(PMPCfg[idx*8+3 +: 2], PMPAdr[idx*AW +: AW],
                                 PMPAdr[pidx*AW +: AW], idx == 0, end_q);
            permit = (mmode_q & ~PMPCfg[idx*8+7]) | (|(type_q & PMPCfg[idx*8 +: 3]));
            if (!hit && (s || e)) begin
                hit       = 1'b1;
                hit_idx   = IW'(idx);
                hit_fault = (s && e) ? ~permit : 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ReqValid) state_d = end_full[PA_BITS] ? DONE : SCAN;
            SCAN: if (!CfgUpdate && (hit || last_grp)) state_d = DONE;
            DONE: if (RespReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ReqReady  = (state_q == IDLE);
        RespValid = (state_q == DONE);
    end

    always_comb begin
        grp_d     = grp_q;
        adr_d     = adr_q;
        end_d     = end_q;
        type_d    = type_q;
        mmode_d   = mmode_q;
        fault_d   = fault_q;
        matched_d = matched_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: if (ReqValid) begin
                adr_d     = ReqAdr[PA_BITS-1:2];
                end_d     = end_full[PA_BITS-1:2];
                type_d    = ReqType;
                mmode_d   = ReqMMode;
                grp_d     = '0;
                fault_d   = end_full[PA_BITS];
                matched_d = 1'b0;
                idx_d     = '0;
            end
            SCAN: begin
                // A config change restarts the scan even if this cycle also decided.
                if (CfgUpdate) begin
                    grp_d = '0;
                end else if (hit) begin
                    fault_d   = hit_fault;
                    matched_d = 1'b1;
                    idx_d     = hit_idx;
                end else if (last_grp) begin
                    fault_d   = ~mmode_q;
                    matched_d = 1'b0;
                    idx_d     = '0;
                end else begin
                    grp_d = grp_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grp_q     <= '0;
            adr_q     <= '0;
            end_q     <= '0;
            type_q    <= '0;
            mmode_q   <= 1'b0;
            fault_q   <= 1'b0;
            matched_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            grp_q     <= grp_d;
            adr_q     <= adr_d;
            end_q     <= end_d;
            type_q    <= type_d;
            mmode_q   <= mmode_d;
            fault_q   <= fault_d;
            matched_q <= matched_d;
            idx_q     <= idx_d;
        end
    end

    assign RespFault   = fault_q;
    assign RespMatched = matched_q;
    assign RespIdx     = idx_q;

endmodule

// File: tb/tb_pmp_scan_checker.sv
// Directed bench for pmp_scan_checker: a byte-range PMP model predicts each response,
// a compare process checks every valid response cycle, and literals pin key cases.
module tb_pmp_scan_checker;

    localparam int PA = 56;
    localparam int NE = 16;
    localparam int LN = 4;
    localparam int AW = PA - 2;

    logic              clk;
    logic              reset;
    logic              ReqValid;
    logic              ReqReady;
    logic [PA-1:0]     ReqAdr;
    logic [1:0]        ReqSize;
    logic [2:0]        ReqType;
    logic              ReqMMode;
    logic [8*NE-1:0]   PMPCfg;
    logic [AW*NE-1:0]  PMPAdr;
    logic              CfgUpdate;
    logic              RespValid;
    logic              RespReady;
    logic              RespFault;
    logic              RespMatched;
    logic [4:0]        RespIdx;

    int tests = 0;
    int fails = 0;

    logic       exp_fault;
    logic       exp_matched;
    logic [4:0] exp_idx;

    pmp_scan_checker #(.PA_BITS(PA), .NUM_ENTRIES(NE), .LANES(LN), .G(0)) dut (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqAdr(ReqAdr), .ReqSize(ReqSize), .ReqType(ReqType), .ReqMMode(ReqMMode),
        .PMPCfg(PMPCfg), .PMPAdr(PMPAdr), .CfgUpdate(CfgUpdate),
        .RespValid(RespValid), .RespReady(RespReady), .RespFault(RespFault),
        .RespMatched(RespMatched), .RespIdx(RespIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && RespValid) begin
            chk("resp_fault", RespFault, exp_fault);
            chk("resp_matched", RespMatched, exp_matched);
            chk("resp_idx", RespIdx, exp_idx);
            chk("ready_low_in_done", ReqReady, 0);
        end
    end

    task automatic set_entry(input int i, input logic [7:0] c, input logic [AW-1:0] a);
        PMPCfg[i*8 +: 8]  = c;
        PMPAdr[i*AW +: AW] = a;
    endtask

    task automatic clear_all();
        PMPCfg = '0;
        PMPAdr = '0;
    endtask

    // Byte range [lo, hi) covered by entry i; an empty range never matches.
    task automatic region(input int i, output longint unsigned lo, output longint unsigned hi);
        logic [7:0]      c;
        logic [AW-1:0]   cur;
        logic [AW-1:0]   prv;
        longint unsigned sz;
        int              t;
        c   = PMPCfg[i*8 +: 8];
        cur = PMPAdr[i*AW +: AW];
        prv = '0;
        if (i > 0) prv = PMPAdr[(i-1)*AW +: AW];
        lo = 0;
        hi = 0;
        case (c[4:3])
            2'b01: begin
                lo = 64'(prv) << 2;
                hi = 64'(cur) << 2;
            end
            2'b10: begin
                lo = 64'(cur) << 2;
                hi = lo + 4;
            end
            2'b11: begin
                t = 0;
                while (t < AW && cur[t]) t++;
                sz = 64'd1 << (t + 3);
                lo = (64'(cur) << 2) & ~(sz - 1);
                hi = lo + sz;
            end
            default: ;
        endcase
    endtask

    task automatic model(input logic [PA-1:0] adr, input int sz, input logic [2:0] typ,
                         input bit m, output bit f, output bit mt, output int idx,
                         output int groups);
        longint unsigned first;
        longint unsigned last;
        longint unsigned lo;
        longint unsigned hi;
        bit s;
        bit e;
        first  = 64'(adr);
        last   = first + (64'd1 << sz) - 1;
        f      = !m;
        mt     = 0;
        idx    = 0;
        groups = NE / LN;
        if (last >= (64'd1 << PA)) begin
            f      = 1;
            groups = 0;
            return;
        end
        for (int i = 0; i < NE; i++) begin
            region(i, lo, hi);
            s = (first >= lo) && (first < hi);
            e = (last >= lo) && (last < hi);
            if (s || e) begin
                mt     = 1;
                idx    = i;
                groups = i / LN + 1;
                if (s && e)
                    f = !((m && !PMPCfg[i*8+7]) || ((typ & PMPCfg[i*8 +: 3]) != 0));
                else
                    f = 1;
                return;
            end
        end
    endtask

    task automatic run_req(input string tag, input logic [PA-1:0] adr, input int sz,
                           input logic [2:0] typ, input bit m, input int upd, input int hold,
                           output int lat_o, output logic f_o, output logic m_o,
                           output logic [4:0] i_o);
        bit f;
        bit mt;
        int idx;
        int groups;
        int exp_lat;
        int cyc;
        model(adr, sz, typ, m, f, mt, idx, groups);
        exp_fault   = f;
        exp_matched = mt;
        exp_idx     = 5'(idx);
        exp_lat     = 1 + groups + ((upd >= 1 && upd <= groups) ? upd : 0);
        @(negedge clk);
        ReqAdr   = adr;
        ReqSize  = 2'(sz);
        ReqType  = typ;
        ReqMMode = m;
        ReqValid = 1;
        chk({tag, "_req_ready"}, ReqReady, 1);
        @(negedge clk);
        ReqValid = 0;
        cyc = 1;
        while (cyc <= 40) begin
            CfgUpdate = (cyc == upd);
            if (RespValid) break;
            @(negedge clk);
            cyc++;
        end
        CfgUpdate = 0;
        lat_o = cyc;
        f_o   = RespFault;
        m_o   = RespMatched;
        i_o   = RespIdx;
        chk({tag, "_latency"}, cyc, exp_lat);
        if (!RespValid) begin
            reset = 1;
            @(negedge clk);
            reset = 0;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            CfgUpdate = (h == 0);
            @(negedge clk);
            CfgUpdate = 0;
            chk({tag, "_hold_valid"}, RespValid, 1);
            chk({tag, "_hold_fault"}, RespFault, f_o);
            chk({tag, "_hold_idx"}, RespIdx, i_o);
        end
        RespReady = 1;
        @(negedge clk);
        RespReady = 0;
        chk({tag, "_released"}, RespValid, 0);
        chk({tag, "_idle_ready"}, ReqReady, 1);
    endtask

    initial begin
        int         lat;
        logic       f;
        logic       mt;
        logic [4:0] ix;
        reset = 1; ReqValid = 0; ReqAdr = '0; ReqSize = '0; ReqType = '0; ReqMMode = 0;
        CfgUpdate = 0; RespReady = 0;
        exp_fault = 0; exp_matched = 0; exp_idx = '0;
        clear_all();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", RespValid, 0);
        chk("rst_ready", ReqReady, 1);
        chk("rst_fault", RespFault, 0);
        chk("rst_matched", RespMatched, 0);
        chk("rst_idx", RespIdx, 0);
        reset = 0;

        // NAPOT 4 KiB at 0, R only
        set_entry(0, 8'h19, 54'h1FF);
        run_req("napot_in", 56'h100, 2, 3'b001, 0, 0, 3, lat, f, mt, ix);
        chk("lit_napot_in_lat", lat, 2);
        chk("lit_napot_in_fault", f, 0);
        chk("lit_napot_in_matched", mt, 1);
        chk("lit_napot_in_idx", ix, 0);
        run_req("napot_straddle", 56'hFFC, 3, 3'b001, 0, 0, 1, lat, f, mt, ix);
        chk("lit_straddle_fault", f, 1);
        chk("lit_straddle_matched", mt, 1);

        // TOR pair: E0 [0,0x1000) no perms, E1 [0x1000,0x2000) R
        clear_all();
        set_entry(0, 8'h08, 54'h400);
        set_entry(1, 8'h09, 54'h800);
        run_req("tor_e1", 56'h1800, 2, 3'b001, 0, 0, 1, lat, f, mt, ix);
        chk("lit_tor_e1_idx", ix, 1);
        chk("lit_tor_e1_fault", f, 0);
        run_req("tor_miss", 56'h2000, 2, 3'b001, 0, 0, 1, lat, f, mt, ix);
        chk("lit_tor_miss_matched", mt, 0);
        chk("lit_tor_miss_fault", f, 1);
        chk("lit_tor_miss_lat", lat, 5);
        run_req("tor_e0_noperm", 56'h800, 2, 3'b001, 0, 0, 1, lat, f, mt, ix);
        set_entry(1, 8'h09, 54'h200);
        run_req("tor_empty", 56'h1800, 2, 3'b001, 0, 0, 1, lat, f, mt, ix);

        // Nothing enabled
        clear_all();
        run_req("off_m", 56'h100, 2, 3'b010, 1, 0, 1, lat, f, mt, ix);
        chk("lit_off_m_fault", f, 0);
        chk("lit_off_m_matched", mt, 0);
        chk("lit_off_m_lat", lat, 5);
        run_req("off_u", 56'h100, 2, 3'b010, 0, 0, 1, lat, f, mt, ix);
        chk("lit_off_u_fault", f, 1);

        // Lock bit applies to M-mode
        set_entry(0, 8'h99, 54'h1FF);
        run_req("locked_m", 56'h100, 2, 3'b010, 1, 0, 1, lat, f, mt, ix);
        chk("lit_locked_m_fault", f, 1);
        set_entry(0, 8'h19, 54'h1FF);
        run_req("unlocked_m", 56'h100, 2, 3'b010, 1, 0, 1, lat, f, mt, ix);
        chk("lit_unlocked_m_fault", f, 0);

        // NA4 on entry 3 covering 0x100..0x103, RW
        clear_all();
        set_entry(3, 8'h13, 54'h40);
        run_req("na4_in", 56'h100, 2, 3'b010, 0, 0, 1, lat, f, mt, ix);
        chk("lit_na4_idx", ix, 3);
        run_req("na4_part", 56'h100, 3, 3'b010, 0, 0, 1, lat, f, mt, ix);
        run_req("na4_half", 56'h102, 1, 3'b001, 0, 0, 1, lat, f, mt, ix);
        run_req("na4_x", 56'h100, 2, 3'b100, 0, 0, 1, lat, f, mt, ix);

        // Entry 15 only: restarts from CfgUpdate during SCAN
        clear_all();
        set_entry(15, 8'h19, 54'h1FF);
        run_req("e15", 56'h100, 2, 3'b001, 0, 0, 1, lat, f, mt, ix);
        chk("lit_e15_lat", lat, 5);
        run_req("e15_upd1", 56'h100, 2, 3'b001, 0, 1, 1, lat, f, mt, ix);
        chk("lit_e15_upd1_lat", lat, 6);
        chk("lit_e15_upd1_idx", ix, 15);
        run_req("e15_upd2", 56'h100, 2, 3'b001, 0, 2, 1, lat, f, mt, ix);
        run_req("e15_upd_decide", 56'h100, 2, 3'b001, 0, 4, 2, lat, f, mt, ix);
        chk("lit_e15_upd_decide_lat", lat, 9);

        // Address wrap past the top of PA space
        clear_all();
        run_req("carry", 56'hFF_FFFF_FFFF_FFFE, 2, 3'b001, 1, 0, 1, lat, f, mt, ix);
        chk("lit_carry_lat", lat, 1);
        chk("lit_carry_fault", f, 1);
        chk("lit_carry_matched", mt, 0);
        run_req("top_nocarry", 56'hFF_FFFF_FFFF_FFFC, 2, 3'b001, 1, 0, 1, lat, f, mt, ix);
        set_entry(0, 8'h1F, 54'h3F_FFFF_FFFF_FFFF);
        run_req("napot_all", 56'hFF_FFFF_FFFF_FFF8, 3, 3'b100, 0, 0, 1, lat, f, mt, ix);

        // Reset in the middle of a scan
        clear_all();
        @(negedge clk);
        ReqAdr = 56'h100; ReqSize = 2; ReqType = 3'b001; ReqMMode = 1; ReqValid = 1;
        @(negedge clk);
        ReqValid = 0;
        @(negedge clk);
        reset = 1;
        #1;
        chk("midscan_rst_valid", RespValid, 0);
        chk("midscan_rst_ready", ReqReady, 1);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("post_rst_valid", RespValid, 0);
        chk("post_rst_ready", ReqReady, 1);
        chk("post_rst_matched", RespMatched, 0);
        run_req("after_rst", 56'h100, 2, 3'b001, 0, 0, 1, lat, f, mt, ix);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
